// File: rtl/fifo_ptr_ctrl_pkg.sv
// rtl/fifo_ptr_ctrl_pkg.sv - shared FIFO sizing constants and helpers
// Purpose: default address width and almost-flag thresholds shared by the
//          pointer controller, the FIFO RAM and the FIFO top level.
// Ports:   none (package).
package fifo_ptr_ctrl_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AFULL_TH  = 14;
  localparam int DEF_AEMPTY_TH = 2;

  // Number of RAM entries for a given address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// rtl/fifo_ptr_ctrl_if.sv - request/status bundle between user logic and the FIFO controller
// Purpose: groups the user request strobes and the RAM strobes/status of the
//          FIFO pointer controller.
// Ports:   master - user side: drives wr/rd/flush/clr_err, observes status.
//          slave  - controller side: observes requests, drives strobes/status.
interface fifo_ptr_ctrl_if
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              wr;
  logic              rd;
  logic              flush;
  logic              clr_err;
  logic              fifo_we;
  logic              fifo_re;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, rd, flush, clr_err,
    input  fifo_we, fifo_re, waddr, raddr, wptr, rptr, count,
    input  fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr, rd, flush, clr_err,
    output fifo_we, fifo_re, waddr, raddr, wptr, rptr, count,
    output fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_cnt.sv
// rtl/fifo_ptr_cnt.sv - wrapping FIFO pointer register
// Purpose: W-bit pointer with async reset, sync clear and increment enable;
//          wraps naturally modulo 2**W.
// Ports:   clk, rst_n (async active-low), clr (sync clear, beats inc),
//          inc (advance by one), q (pointer value).
module fifo_ptr_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer, status and error controller
// Purpose: holds write/read pointers, gates requests into RAM strobes, derives
//          count, full/empty/almost flags and sticky overflow/underflow.
// Ports:   clk, rst_n (async active-low);
//          bus (slave): wr/rd/flush/clr_err in; fifo_we/fifo_re, waddr/raddr,
//          wptr/rptr, count, fifo_full/fifo_empty, almost_full/almost_empty,
//          overflow/underflow out.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int            PW       = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          we;
  logic          re;
  logic          overflow;
  logic          underflow;

  // Status comes only from registered pointers, never from this cycle's requests.
  assign count = wptr - rptr;
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty = (wptr == rptr);

  // Flush swallows both requests, so a flush cycle never moves a pointer on its own.
  assign we = bus.wr & ~full  & ~bus.flush;
  assign re = bus.rd & ~empty & ~bus.flush;

  fifo_ptr_cnt #(.W(PW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (we),
    .q     (wptr)
  );

  fifo_ptr_cnt #(.W(PW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (re),
    .q     (rptr)
  );

  // Sticky errors: a fresh error in the clearing cycle must not be lost, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (bus.wr && full && !bus.flush) begin
        overflow <= 1'b1;
      end
      if (bus.rd && empty && !bus.flush) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.fifo_we      = we;
  assign bus.fifo_re      = re;
  assign bus.waddr        = wptr[ADDR_W-1:0];
  assign bus.raddr        = rptr[ADDR_W-1:0];
  assign bus.wptr         = wptr;
  assign bus.rptr         = rptr;
  assign bus.count        = count;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count >= AFULL_V);
  assign bus.almost_empty = (count <= AEMPTY_V);
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule
